// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine -- SD-bus CMD-line engine.
//
// Sends one 48-bit command frame (start 0, transmission 1, index, argument,
// CRC7, end 1) MSB first, one bit per sd_clk_en tick. It then optionally
// waits for a 48-bit response, checks it and presents its index and
// argument fields.
//
// Build option:
//   SD_RESP_CRC_CHECK_EN -- when defined, the response CRC7 is recomputed
//                           and compared.  When undefined, only the
//                           response end bit is checked.
//
// Parameter:
//   NCR_MAX      maximum number of ticks to wait for the response start bit
//
// Ports:
//   clk          system clock (rising edge)
//   resetn       asynchronous active-low reset
//   sd_clk_en    bit-tick enable, one CMD bit per tick
//   cmd_start    command request, honoured only when idle
//   cmd_index    command index (captured on accept)
//   cmd_arg      command argument (captured on accept)
//   resp_en      1 = expect a 48-bit response (captured on accept)
//   sd_cmd_in    CMD line input
//   sd_cmd_out   CMD line drive value
//   sd_cmd_oe    CMD line output enable
//   busy         operation in progress
//   cmd_done     one-cycle completion pulse
//   resp_timeout no response start bit within NCR_MAX ticks
//   resp_crc_err response CRC7 and/or end-bit error
//   resp_index   response bits [45:40]
//   resp_arg     response bits [39:8]
module sd_cmd_engine #(
   parameter int NCR_MAX = 64
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sd_clk_en,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   input  logic        resp_en,
   input  logic        sd_cmd_in,
   output logic        sd_cmd_out,
   output logic        sd_cmd_oe,
   output logic        busy,
   output logic        cmd_done,
   output logic        resp_timeout,
   output logic        resp_crc_err,
   output logic [5:0]  resp_index,
   output logic [31:0] resp_arg
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_TX   = 3'd1,
      ST_WAIT = 3'd2,
      ST_RX   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int             WCW       = $clog2(NCR_MAX + 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(NCR_MAX - 1);
   localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

   // The response history keeps the transmission bit only when it takes part
   // in the CRC.  The start bit is consumed in WAIT, and the end bit is taken
   // live from sd_cmd_in on the last RX tick.
`ifdef SD_RESP_CRC_CHECK_EN
   localparam int RXW = 46;
`else
   localparam int RXW = 45;
`endif

   // CRC7, polynomial x^7 + x^3 + 1, initial value 0, MSB first.
   function automatic logic [6:0] crc7_calc(input logic [39:0] data);
      logic [6:0] crc;
      logic       fb;
      crc = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb  = data[i] ^ crc[6];
         crc = {crc[5:0], 1'b0};
         if (fb) begin
            crc = crc ^ 7'h09;
         end else begin
            crc = crc;
         end
      end
      return crc;
   endfunction

   function automatic logic [47:0] build_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [39:0] head;
      head = {2'b01, idx, arg};
      return {head, crc7_calc(head), 1'b1};
   endfunction

   state_t         state_r;
   state_t         state_nxt_s;
   logic [47:0]    frame_r;
   logic [5:0]     bit_cnt_r;
   logic [WCW-1:0] wait_cnt_r;
   logic           resp_en_r;
   logic [RXW-1:0] rx_sr_r;
   logic           rx_bad_s;

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.  Every move except IDLE->TX and DONE->IDLE waits for a tick.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cmd_start) state_nxt_s = ST_TX;
            else           state_nxt_s = ST_IDLE;
         end
         ST_TX: begin
            // bit_cnt_r == 48: the end bit has been on the line for one full tick.
            if (sd_clk_en && (bit_cnt_r == 6'd48)) state_nxt_s = resp_en_r ? ST_WAIT : ST_DONE;
            else                                   state_nxt_s = ST_TX;
         end
         ST_WAIT: begin
            if (!sd_clk_en)                    state_nxt_s = ST_WAIT;
            else if (!sd_cmd_in)               state_nxt_s = ST_RX;
            else if (wait_cnt_r == WAIT_LAST)  state_nxt_s = ST_DONE;
            else                               state_nxt_s = ST_WAIT;
         end
         ST_RX: begin
            if (sd_clk_en && (bit_cnt_r == 6'd46)) state_nxt_s = ST_DONE;
            else                                   state_nxt_s = ST_RX;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Response check, evaluated on the last RX tick. sd_cmd_in is then the end bit.
`ifdef SD_RESP_CRC_CHECK_EN
   always_comb begin
      rx_bad_s = (crc7_calc({1'b0, rx_sr_r[45:7]}) != rx_sr_r[6:0]) || !sd_cmd_in;
   end
`else
   always_comb begin
      rx_bad_s = !sd_cmd_in;
   end
`endif

   // Datapath and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         frame_r      <= 48'hFFFF_FFFF_FFFF;
         bit_cnt_r    <= 6'd0;
         wait_cnt_r   <= '0;
         resp_en_r    <= 1'b0;
         rx_sr_r      <= '0;
         sd_cmd_out   <= 1'b1;
         sd_cmd_oe    <= 1'b0;
         busy         <= 1'b0;
         cmd_done     <= 1'b0;
         resp_timeout <= 1'b0;
         resp_crc_err <= 1'b0;
         resp_index   <= 6'd0;
         resp_arg     <= 32'd0;
      end else begin
         // Control outputs follow the state being entered, so they are aligned with it.
         cmd_done  <= (state_nxt_s == ST_DONE);
         busy      <= (state_nxt_s != ST_IDLE);
         sd_cmd_oe <= (state_nxt_s == ST_TX);
         case (state_r)
            ST_IDLE: begin
               sd_cmd_out <= 1'b1;
               if (cmd_start) begin
                  frame_r      <= build_frame(cmd_index, cmd_arg);
                  resp_en_r    <= resp_en;
                  bit_cnt_r    <= 6'd0;
                  wait_cnt_r   <= '0;
                  resp_timeout <= 1'b0;
                  resp_crc_err <= 1'b0;
                  resp_index   <= 6'd0;
                  resp_arg     <= 32'd0;
               end else begin
                  bit_cnt_r    <= bit_cnt_r;
               end
            end
            ST_TX: begin
               if (sd_clk_en) begin
                  if (bit_cnt_r == 6'd48) begin
                     sd_cmd_out <= 1'b1;
                  end else begin
                     sd_cmd_out <= frame_r[47];
                     frame_r    <= {frame_r[46:0], 1'b1};
                     bit_cnt_r  <= bit_cnt_r + 6'd1;
                  end
               end else begin
                  sd_cmd_out <= sd_cmd_out;
               end
            end
            ST_WAIT: begin
               sd_cmd_out <= 1'b1;
               if (sd_clk_en) begin
                  if (!sd_cmd_in) begin
                     bit_cnt_r <= 6'd0;
                  end else if (wait_cnt_r == WAIT_LAST) begin
                     resp_timeout <= 1'b1;
                  end else begin
                     wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                  end
               end else begin
                  wait_cnt_r <= wait_cnt_r;
               end
            end
            ST_RX: begin
               sd_cmd_out <= 1'b1;
               if (sd_clk_en) begin
                  rx_sr_r <= {rx_sr_r[RXW-2:0], sd_cmd_in};
                  if (bit_cnt_r == 6'd46) begin
                     resp_index   <= rx_sr_r[44:39];
                     resp_arg     <= rx_sr_r[38:7];
                     resp_crc_err <= rx_bad_s;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 6'd1;
                  end
               end else begin
                  rx_sr_r <= rx_sr_r;
               end
            end
            ST_DONE: begin
               sd_cmd_out <= 1'b1;
            end
            default: begin
               sd_cmd_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed testbench for sd_cmd_engine: command frames, card response model,
// timeout, response errors, clock-enable stalls, ignored cmd_start, reset abort.
module tb_sd_cmd_engine;

   logic        clk = 1'b0;
   logic        resetn;
   logic        sd_clk_en;
   logic        cmd_start;
   logic [5:0]  cmd_index;
   logic [31:0] cmd_arg;
   logic        resp_en;
   logic        sd_cmd_in;
   logic        sd_cmd_out;
   logic        sd_cmd_oe;
   logic        busy;
   logic        cmd_done;
   logic        resp_timeout;
   logic        resp_crc_err;
   logic [5:0]  resp_index;
   logic [31:0] resp_arg;

`ifdef SD_RESP_CRC_CHECK_EN
   localparam logic EXP_CRC_FLIP = 1'b1;
`else
   localparam logic EXP_CRC_FLIP = 1'b0;
`endif

   always #5 clk = ~clk;

   sd_cmd_engine #(.NCR_MAX(64)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .sd_clk_en    (sd_clk_en),
      .cmd_start    (cmd_start),
      .cmd_index    (cmd_index),
      .cmd_arg      (cmd_arg),
      .resp_en      (resp_en),
      .sd_cmd_in    (sd_cmd_in),
      .sd_cmd_out   (sd_cmd_out),
      .sd_cmd_oe    (sd_cmd_oe),
      .busy         (busy),
      .cmd_done     (cmd_done),
      .resp_timeout (resp_timeout),
      .resp_crc_err (resp_crc_err),
      .resp_index   (resp_index),
      .resp_arg     (resp_arg)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Results of the last run_cmd
   logic [47:0] cap_frame;
   int          cap_bits, done_cnt, done_tick, hold_err, oe_err, latency;
   logic        r_timeout, r_crc, busy_start, busy_after, clr_flags, finished;
   logic [5:0]  r_index;
   logic [31:0] r_arg;
   logic        ab_oe, ab_out, ab_busy;

   // Issue a command and play the card. div = tick period in clk cycles;
   // delay = ticks of idle line before the response start bit.
   task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                          input logic [47:0] resp, input int delay, input int div,
                          input int glitch_bit, input int abort_bit);
      int   c, n, t, k, post, last_cyc;
      bit   card_active, tx_seen, tick_prev, glitched;
      logic out_prev;
      cap_frame = 48'd0; cap_bits = 0; done_cnt = 0; done_tick = -1; hold_err = 0;
      oe_err = 0; latency = -1; finished = 1'b0;
      c = 0; n = 0; post = 0; last_cyc = 0;
      card_active = 1'b0; tx_seen = 1'b0; tick_prev = 1'b0; glitched = 1'b0; out_prev = 1'b1;
      @(negedge clk);
      cmd_index = idx; cmd_arg = arg; resp_en = ren; cmd_start = 1'b1;
      sd_clk_en = 1'b0; sd_cmd_in = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0; cmd_index = 6'h3F; cmd_arg = 32'hFFFF_FFFF; resp_en = ~ren;
      busy_start = busy;
      clr_flags  = resp_timeout | resp_crc_err | (|resp_index) | (|resp_arg);
      while (!finished && c < 3000) begin
         // observe the result of the previous rising edge
         if (tick_prev && card_active) n++;
         if (tick_prev && sd_cmd_oe) begin
            cap_frame = {cap_frame[46:0], sd_cmd_out};
            cap_bits++;
            tx_seen = 1'b1;
            last_cyc = c;
         end else if (sd_cmd_oe && tx_seen && sd_cmd_out !== out_prev) begin
            hold_err++;
         end
         out_prev = sd_cmd_out;
         if (tx_seen && !sd_cmd_oe && !card_active && ren) begin
            card_active = 1'b1;
            n = 0;
         end
         if (card_active && sd_cmd_oe) oe_err++;
         if (cmd_done) begin
            if (done_cnt == 0) latency = c - last_cyc;
            done_cnt++;
            done_tick = n;
            r_timeout = resp_timeout; r_crc = resp_crc_err;
            r_index = resp_index; r_arg = resp_arg;
         end
         if (abort_bit >= 0 && cap_bits == abort_bit) begin
            resetn = 1'b0;
            #1;
            ab_oe = sd_cmd_oe; ab_out = sd_cmd_out; ab_busy = busy;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               if (cmd_done) done_cnt++;
            end
            resetn = 1'b1;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (cmd_done) done_cnt++;
            end
            finished = 1'b1;
         end else begin
            if (done_cnt > 0) begin
               post++;
               if (post == 2) busy_after = busy;
               if (post >= 20) finished = 1'b1;
            end
            // drive inputs for the next rising edge
            if (glitch_bit >= 0 && cap_bits == glitch_bit && !glitched) begin
               cmd_start = 1'b1;
               glitched = 1'b1;
            end else begin
               cmd_start = 1'b0;
            end
            tick_prev = ((c % div) == 0);
            sd_clk_en = tick_prev;
            t = n + 1;
            if (!card_active || t <= delay) begin
               sd_cmd_in = 1'b1;
            end else begin
               k = t - delay - 1;
               sd_cmd_in = (k > 47) ? 1'b1 : resp[47 - k];
            end
            c++;
            if (!finished) @(negedge clk);
         end
      end
      cmd_start = 1'b0;
      sd_cmd_in = 1'b1;
      check_eq("cycle_bound", 64'(finished), 64'd1);
   endtask

   initial begin
      resetn = 1'b0; sd_clk_en = 1'b0; cmd_start = 1'b0; cmd_index = 6'd0;
      cmd_arg = 32'd0; resp_en = 1'b0; sd_cmd_in = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_out",     64'(sd_cmd_out),   64'd1);
      check_eq("rst_oe",      64'(sd_cmd_oe),    64'd0);
      check_eq("rst_busy",    64'(busy),         64'd0);
      check_eq("rst_done",    64'(cmd_done),     64'd0);
      check_eq("rst_timeout", 64'(resp_timeout), 64'd0);
      check_eq("rst_crc",     64'(resp_crc_err), 64'd0);
      check_eq("rst_index",   64'(resp_index),   64'd0);
      check_eq("rst_arg",     64'(resp_arg),     64'd0);
      resetn = 1'b1;
      @(negedge clk);

      // CMD0, no response, tick every cycle
      run_cmd(6'd0, 32'd0, 1'b0, 48'd0, 0, 1, -1, -1);
      check_eq("cmd0_frame",   64'(cap_frame),  64'h4000_0000_0095);
      check_eq("cmd0_bits",    64'(cap_bits),   64'd48);
      check_eq("cmd0_dones",   64'(done_cnt),   64'd1);
      check_eq("cmd0_latency", 64'(latency),    64'd1);
      check_eq("cmd0_busy0",   64'(busy_start), 64'd1);
      check_eq("cmd0_busy1",   64'(busy_after), 64'd0);
      check_eq("cmd0_oe_end",  64'(sd_cmd_oe),  64'd0);

      // CMD8 with a good R7 response after 5 idle ticks
      run_cmd(6'd8, 32'h0000_01AA, 1'b1, 48'h0800_0001_AA13, 5, 1, -1, -1);
      check_eq("cmd8_frame",   64'(cap_frame), 64'h4800_0001_AA87);
      check_eq("cmd8_ticks",   64'(done_tick), 64'd53);
      check_eq("cmd8_timeout", 64'(r_timeout), 64'd0);
      check_eq("cmd8_crc",     64'(r_crc),     64'd0);
      check_eq("cmd8_index",   64'(r_index),   64'd8);
      check_eq("cmd8_arg",     64'(r_arg),     64'h1AA);
      check_eq("cmd8_oe_rx",   64'(oe_err),    64'd0);
      check_eq("cmd8_hold_ix", 64'(resp_index), 64'd8);

      // No response: timeout exactly 64 ticks after the end bit
      run_cmd(6'd8, 32'h0000_01AA, 1'b1, 48'hFFFF_FFFF_FFFF, 1000, 1, -1, -1);
      check_eq("to_clear",   64'(clr_flags), 64'd0);
      check_eq("to_ticks",   64'(done_tick), 64'd64);
      check_eq("to_flag",    64'(r_timeout), 64'd1);
      check_eq("to_index",   64'(r_index),   64'd0);
      check_eq("to_arg",     64'(r_arg),     64'd0);
      check_eq("to_held",    64'(resp_timeout), 64'd1);

      // Response with CRC LSB flipped
      run_cmd(6'd8, 32'h0000_01AA, 1'b1, 48'h0800_0001_AA11, 2, 1, -1, -1);
      check_eq("crcbad_to_clr", 64'(r_timeout), 64'd0);
      check_eq("crcbad_flag",   64'(r_crc),     64'(EXP_CRC_FLIP));
      check_eq("crcbad_index",  64'(r_index),   64'd8);

      // Response with end bit forced to 0
      run_cmd(6'd8, 32'h0000_01AA, 1'b1, 48'h0800_0001_AA12, 3, 1, -1, -1);
      check_eq("endbad_flag",  64'(r_crc),   64'd1);
      check_eq("endbad_arg",   64'(r_arg),   64'h1AA);

      // CMD0 with a tick every 4 cycles and a stray cmd_start mid-frame
      run_cmd(6'd0, 32'd0, 1'b0, 48'd0, 0, 4, 10, -1);
      check_eq("div4_frame",   64'(cap_frame), 64'h4000_0000_0095);
      check_eq("div4_bits",    64'(cap_bits),  64'd48);
      check_eq("div4_hold",    64'(hold_err),  64'd0);
      check_eq("div4_dones",   64'(done_cnt),  64'd1);
      check_eq("div4_latency", 64'(latency),   64'd4);

      // Reset at bit 20 of a CMD0 frame, then a fresh CMD0
      run_cmd(6'd0, 32'd0, 1'b0, 48'd0, 0, 1, -1, 20);
      check_eq("abort_oe",    64'(ab_oe),    64'd0);
      check_eq("abort_out",   64'(ab_out),   64'd1);
      check_eq("abort_busy",  64'(ab_busy),  64'd0);
      check_eq("abort_dones", 64'(done_cnt), 64'd0);
      run_cmd(6'd0, 32'd0, 1'b0, 48'd0, 0, 1, -1, -1);
      check_eq("rerun_frame", 64'(cap_frame), 64'h4000_0000_0095);
      check_eq("rerun_dones", 64'(done_cnt),  64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_cmd_engine.md
SD_CMD_ENGINE -- requirements
Module: sd_cmd_engine

Interface
REQ-001 Parameter: NCR_MAX, 64, maximum response wait in bit ticks after the command end bit.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 sd_clk_en  input  1  bit-tick enable; one SD bit shifts per clk cycle where high.
REQ-005 cmd_start  input  1  one-cycle request to issue a command; sampled only in IDLE.
REQ-006 cmd_index  input  6  command index, from the register-set command area; captured on accepted cmd_start.
REQ-007 cmd_arg  input  32  command argument; captured on accepted cmd_start.
REQ-008 resp_en  input  1  1 = expect 48-bit response, 0 = no response; captured on accepted cmd_start.
REQ-009 sd_cmd_in  input  1  CMD line input.
REQ-010 sd_cmd_out  output  1  CMD line drive value.
REQ-011 sd_cmd_oe  output  1  CMD line output enable (1 = drive).
REQ-012 busy  output  1  high from accepted cmd_start until the cycle after cmd_done.
REQ-013 cmd_done  output  1  one-cycle completion pulse.
REQ-014 resp_timeout  output  1  no start bit within NCR_MAX ticks; valid with cmd_done, held until next accepted cmd_start.
REQ-015 resp_crc_err  output  1  response CRC7 or end-bit error; valid with cmd_done, held until next accepted cmd_start.
REQ-016 resp_index  output  6  response bits [45:40]; held until next accepted cmd_start.
REQ-017 resp_arg  output  32  response bits [39:8]; held until next accepted cmd_start.

Function
REQ-018 States: IDLE, TX, WAIT, RX, DONE; DONE lasts exactly one clk cycle and asserts cmd_done.
REQ-019 IDLE -> TX on cmd_start; captures inputs, clears resp_timeout, resp_crc_err, resp_index, resp_arg.
REQ-020 TX frame, MSB first, 48 bits: 0, 1, cmd_index, cmd_arg, CRC7, 1.
REQ-021 CRC7: polynomial x^7+x^3+1, initial value 0, computed over the first 40 frame bits.
REQ-022 In TX, sd_cmd_oe = 1; sd_cmd_out changes only on cycles where sd_clk_en = 1.
REQ-023 After the end bit's tick: resp_en = 0 -> DONE; resp_en = 1 -> WAIT with sd_cmd_oe = 0.
REQ-024 WAIT: sample sd_cmd_in on each tick; 0 -> RX (start bit consumed); NCR_MAX ticks without 0 -> DONE with resp_timeout = 1.
REQ-025 RX: shift in the remaining 47 bits on ticks, then -> DONE.
REQ-026 Response check: end bit must be 1; bit 46 (transmission bit) is not checked.
REQ-027 sd_clk_en low stalls all state and counters; no timeout progress.
REQ-028 cmd_start outside IDLE is ignored, with no effect on the operation in progress.
REQ-029 sd_cmd_oe is never 1 outside TX.

Reset
REQ-030 While resetn is low: state IDLE, sd_cmd_out = 1, sd_cmd_oe = 0, busy = 0, cmd_done = 0, resp_timeout = 0, resp_crc_err = 0, resp_index = 0, resp_arg = 0.
REQ-031 Reset mid-operation aborts immediately with no cmd_done; the next cmd_start after release starts a fresh frame.

Configuration
REQ-032 Macro SD_RESP_CRC_CHECK_EN defined: resp_crc_err = (received CRC7 != CRC7 over response bits [47:8]) OR end bit = 0.
REQ-033 Macro not defined: CRC hardware is omitted and resp_crc_err reflects only an end-bit error; the TX CRC is always present.

Verification
REQ-034 CMD0: cmd_index = 0, cmd_arg = 0, resp_en = 0, sd_clk_en = 1 -> line carries 0x400000000095; cmd_done one cycle after the last bit; oe then 0.
REQ-035 CMD8: cmd_index = 8, cmd_arg = 0x000001AA, resp_en = 1; card returns 0x08000001AA13 after 5 ticks -> resp_index = 8, resp_arg = 0x000001AA, resp_timeout = 0, resp_crc_err = 0.
REQ-036 resp_en = 1 with sd_cmd_in held at 1 -> cmd_done exactly NCR_MAX = 64 ticks after the end bit; resp_timeout = 1.
REQ-037 Response with one corrupted CRC bit -> resp_crc_err = 1 with macro defined, 0 without it; response end bit forced to 0 -> resp_crc_err = 1 in both builds.
REQ-038 sd_clk_en asserted once every 4 cycles, plus cmd_start pulsed during TX -> frame identical to REQ-034, with each bit held for 4 cycles, and only one cmd_done.
REQ-039 resetn asserted at bit 20 of TX -> oe = 0, out = 1 at once and no cmd_done; a new CMD0 after release -> frame as in REQ-034.
